// File: rtl/muladd_dot_seq.sv
// Sequencer streaming operand pairs into one MULADD BEL (ACC=1, ACCout=1) and returning the 20-bit dot product.
// Optional: define MULADD_DOT_SEQ_ABORT_EN to add an abort input that cancels a run in CLEAR/RUN/DRAIN.
module muladd_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 0
) (
  input  logic             UserCLK,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_clr,
  input  logic [19:0]      mac_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [19:0]      res_data,
`ifdef MULADD_DOT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on the clock edge where valid && ready are both high;
  // op_ready never depends on op_valid, and res_valid/res_data hold until res_ready is seen.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] issued_inc;
  logic             drain_cnt;
  logic             accept;
  logic             abort_hit;
  logic             clr_n;

`ifdef MULADD_DOT_SEQ_ABORT_EN
  assign abort_hit = abort && (state == S_CLEAR || state == S_RUN || state == S_DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  assign issued_inc = issued + LEN_W'(1);
  assign op_ready   = (state == S_RUN) && (issued < len_q) && !abort_hit;
  assign accept     = op_valid && op_ready;
  assign busy       = (state != S_IDLE);
  assign res_valid  = (state == S_DONE);
  assign dbg_state  = state;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_CLEAR;
      S_CLEAR: state_n = (len_q != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (accept && issued_inc == len_q) state_n = S_DRAIN;
      // The BEL adds a product 1+MAC_LAT edges after issue, so wait that long on zeros.
      S_DRAIN: if (drain_cnt == 1'(MAC_LAT)) state_n = S_CAPT;
      S_CAPT:  state_n = S_DONE;
      S_DONE:  if (res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort_hit) state_n = S_IDLE;
    clr_n = (state_n == S_CLEAR) || abort_hit;
  end

  always_ff @(posedge UserCLK or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      issued    <= '0;
      drain_cnt <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b0;
      res_data  <= '0;
    end else begin
      state   <= state_n;
      mac_clr <= clr_n;
      // Zero operands whenever nothing is issued: the BEL accumulates every clock.
      mac_a   <= accept ? op_a : 8'd0;
      mac_b   <= accept ? op_b : 8'd0;
      if (state == S_IDLE && start) begin
        len_q  <= len;
        issued <= '0;
      end else if (accept) begin
        issued <= issued_inc;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : 1'b0;
      if (state == S_CAPT) res_data <= mac_q;
    end
  end

endmodule

// File: tb/tb_muladd_dot_seq.sv
// Bench for muladd_dot_seq: two instances (MAC_LAT=0 and 1), each driving its own MULADD accumulator model.
module tb_muladd_dot_seq;

  logic        UserCLK = 1'b0;
  logic        rst;
  logic        start     [2];
  logic [7:0]  len       [2];
  logic        busy      [2];
  logic        op_valid  [2];
  logic        op_ready  [2];
  logic [7:0]  op_a      [2];
  logic [7:0]  op_b      [2];
  logic [7:0]  mac_a     [2];
  logic [7:0]  mac_b     [2];
  logic        mac_clr   [2];
  logic [19:0] mac_q     [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [19:0] res_data  [2];
  logic [2:0]  dbg_state [2];
`ifdef MULADD_DOT_SEQ_ABORT_EN
  logic        abort     [2];
`endif

  int tests = 0;
  int fails = 0;

  always #5 UserCLK = ~UserCLK;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [19:0] acc = (g == 0) ? 20'h12345 : 20'h0abcd;
    logic [7:0]  a_r = 8'd0;
    logic [7:0]  b_r = 8'd0;
    logic [7:0]  ea, eb;
    assign ea = (g == 0) ? mac_a[g] : a_r;
    assign eb = (g == 0) ? mac_b[g] : b_r;
    assign mac_q[g] = acc;
    // BEL model: accumulator is not touched by rst, only by clr.
    always @(posedge UserCLK) begin
      a_r <= mac_a[g];
      b_r <= mac_b[g];
      if (mac_clr[g]) acc <= 20'd0;
      else            acc <= acc + {4'd0, ({8'd0, ea} * {8'd0, eb})};
    end

    muladd_dot_seq #(.LEN_W(8), .MAC_LAT(g)) u_dut (
      .UserCLK   (UserCLK),
      .rst       (rst),
      .start     (start[g]),
      .len       (len[g]),
      .busy      (busy[g]),
      .op_valid  (op_valid[g]),
      .op_ready  (op_ready[g]),
      .op_a      (op_a[g]),
      .op_b      (op_b[g]),
      .mac_a     (mac_a[g]),
      .mac_b     (mac_b[g]),
      .mac_clr   (mac_clr[g]),
      .mac_q     (mac_q[g]),
      .res_valid (res_valid[g]),
      .res_ready (res_ready[g]),
      .res_data  (res_data[g]),
`ifdef MULADD_DOT_SEQ_ABORT_EN
      .abort     (abort[g]),
`endif
      .dbg_state (dbg_state[g])
    );
  end

  typedef struct {
    int              inst;
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              gap [4];
    logic [19:0]     exp_res;
    int              lat;
  } vec_t;

  function automatic vec_t mk(int inst, int n,
                              logic [7:0] a0, logic [7:0] a1, logic [7:0] a2, logic [7:0] a3,
                              logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                              int g0, int g1, int g2, int g3, logic [19:0] exp_res);
    vec_t v;
    v.inst = inst; v.n = n;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2; v.gap[3] = g3;
    v.exp_res = exp_res;
    v.lat = 2 + inst;
    return v;
  endfunction

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Feeds one pair and returns after the edge that accepted it.
  task automatic send_pair(input int d, input logic [7:0] a, input logic [7:0] b);
    int to = 0;
    op_valid[d] = 1'b1; op_a[d] = a; op_b[d] = b;
    while (!op_ready[d] && to < 50) begin tick(); to++; end
    if (to >= 50) check("op_ready_timeout", 32'(to), 32'd0);
    tick();
    op_valid[d] = 1'b0; op_a[d] = 8'd0; op_b[d] = 8'd0;
  endtask

  task automatic run_vec(input vec_t v);
    int d = v.inst;
    int cnt = 0;
    start[d] = 1'b1; len[d] = 8'(v.n);
    tick();
    start[d] = 1'b0;
    check("clr_pulse", 32'(mac_clr[d]), 32'd1);
    for (int i = 0; i < v.n; i++) begin
      repeat (v.gap[i % 4]) tick();
      send_pair(d, v.a[i % 4], v.b[i % 4]);
    end
    while (!res_valid[d] && cnt < 50) begin tick(); cnt++; end
    check("res_latency", 32'(cnt), 32'(v.lat));
    check("res_data", 32'(res_data[d]), 32'(v.exp_res));
    res_ready[d] = 1'b1;
    tick();
    res_ready[d] = 1'b0;
    check("idle_after_ack", {30'd0, busy[d], res_valid[d]}, 32'd0);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_op_ready", 32'(op_ready[d]), 32'd0);
    check("rst_mac_ab", {16'd0, mac_a[d], mac_b[d]}, 32'd0);
    check("rst_mac_clr", 32'(mac_clr[d]), 32'd0);
    check("rst_res_valid", 32'(res_valid[d]), 32'd0);
    check("rst_res_data", 32'(res_data[d]), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(0, 3, 2, 4, 1, 0, 3, 5, 7, 0, 0, 0, 0, 0, 20'h00021);
    vecs[1] = mk(1, 3, 2, 4, 1, 0, 3, 5, 7, 0, 0, 2, 5, 0, 20'h00021);
    vecs[2] = mk(0, 16, 255, 255, 255, 255, 255, 255, 255, 255, 0, 0, 0, 0, 20'hFE010);
    vecs[3] = mk(0, 17, 255, 255, 255, 255, 255, 255, 255, 255, 0, 0, 0, 0, 20'h0DE11);
    vecs[4] = mk(1, 16, 255, 255, 255, 255, 255, 255, 255, 255, 0, 1, 0, 0, 20'hFE010);
    vecs[5] = mk(1, 5, 10, 20, 30, 40, 1, 2, 3, 4, 1, 0, 3, 0, 20'd310);
    vecs[6] = mk(0, 2, 200, 100, 0, 0, 50, 0, 0, 0, 0, 3, 0, 0, 20'd10000);
    vecs[7] = mk(1, 1, 9, 0, 0, 0, 11, 0, 0, 0, 4, 0, 0, 0, 20'd99);

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; len[d] = 8'd0; op_valid[d] = 1'b0;
      op_a[d] = 8'd0; op_b[d] = 8'd0; res_ready[d] = 1'b0;
`ifdef MULADD_DOT_SEQ_ABORT_EN
      abort[d] = 1'b0;
`endif
    end
    repeat (2) @(posedge UserCLK);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outputs(d);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Asynchronous reset in the middle of a run, then a fresh run.
    start[0] = 1'b1; len[0] = 8'd5;
    tick();
    start[0] = 1'b0;
    send_pair(0, 8'd5, 8'd6);
    send_pair(0, 8'd7, 8'd8);
    check("pre_rst_mac_a", 32'(mac_a[0]), 32'd7);
    check("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs(0);
    rst = 1'b0;
    tick();
    run_vec(mk(0, 1, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 20'd9));

    // len=0: clear pulse, zero result, result held under back-pressure, start ignored outside IDLE.
    begin
      int cnt = 0;
      start[0] = 1'b1; len[0] = 8'd0;
      tick();
      start[0] = 1'b0;
      check("len0_clr", {30'd0, mac_clr[0], busy[0]}, 32'd3);
      tick();
      check("len0_clr_width", 32'(mac_clr[0]), 32'd0);
      while (!res_valid[0] && cnt < 50) begin tick(); cnt++; end
      check("len0_latency", 32'(cnt), 32'd2);
      check("len0_res", 32'(res_data[0]), 32'd0);
      start[0] = 1'b1; len[0] = 8'd3;
      for (int i = 0; i < 4; i++) begin
        tick();
        check("hold_valid_busy", {30'd0, res_valid[0], busy[0]}, 32'd3);
        check("hold_data", 32'(res_data[0]), 32'd0);
      end
      res_ready[0] = 1'b1;
      tick();
      res_ready[0] = 1'b0; start[0] = 1'b0;
      check("ack_with_start", {30'd0, busy[0], res_valid[0]}, 32'd0);
      tick();
      check("start_ignored", 32'(busy[0]), 32'd0);
    end

`ifdef MULADD_DOT_SEQ_ABORT_EN
    begin
      int seen = 0;
      start[0] = 1'b1; len[0] = 8'd4;
      tick();
      start[0] = 1'b0;
      send_pair(0, 8'd1, 8'd2);
      send_pair(0, 8'd3, 8'd4);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      check("abort_state", {29'd0, busy[0], mac_clr[0], res_valid[0]}, 32'd2);
      tick();
      check("abort_clr_width", 32'(mac_clr[0]), 32'd0);
      for (int i = 0; i < 5; i++) begin
        if (res_valid[0] || busy[0]) seen++;
        tick();
      end
      check("abort_no_result", 32'(seen), 32'd0);
      run_vec(mk(0, 1, 6, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 20'd42));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
